warmboot_seq: RTL

Parametrised, sequenced successor to the combinational warm-boot primitive. It sits between user fabric logic and the external warm-boot/configuration controller.
- Arbitrates boot requests from NUM_REQ user channels.
- Requires a request to be held for ARM_CYCLES before acting, and rejects out-of-range slots.
- Drives a fixed-length BOOT_top pulse with a stable SLOT_top.
- Enforces a cooldown after each boot.
- Stretches the reset it returns to the user design.

---
 rtl/warmboot_seq.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/warmboot_seq.sv
// Warm-boot sequencer: arbitrates user boot requests, arms, fires a fixed
// BOOT_top pulse, enforces a cooldown and stretches the user reset.
module warmboot_seq #(
   parameter int SLOT_BITS     = 4,
   parameter int NUM_REQ       = 2,
   parameter int MAX_SLOT      = 15,
   parameter int ARM_CYCLES    = 4,
   parameter int BOOT_PULSE    = 8,
   parameter int COOLDOWN      = 32,
   parameter int RESET_STRETCH = 16
) (
   input  logic                         UserCLK,
   input  logic                         RST,
   input  logic [NUM_REQ*SLOT_BITS-1:0] SLOT,
   input  logic [NUM_REQ-1:0]           BOOT,
   output logic [NUM_REQ-1:0]           GRANT,
   output logic                         BUSY,
   output logic                         ERR,
   output logic                         RESET,
   output logic [SLOT_BITS-1:0]         SLOT_top,
   output logic                         BOOT_top,
   input  logic                         RESET_top,
   input  logic                         CONFIGURED_top
);

   localparam int CW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int AW  = $clog2(ARM_CYCLES + 1);
   localparam int PW  = $clog2(BOOT_PULSE + 1);
   localparam int DW  = $clog2(COOLDOWN + 1);
   localparam int SW  = (RESET_STRETCH > 0) ? $clog2(RESET_STRETCH + 1) : 1;
   localparam logic [SLOT_BITS-1:0] MAXS = SLOT_BITS'(MAX_SLOT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_FIRE = 2'd2,
      S_COOL = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        chan_q, chan_d;
   logic [SLOT_BITS-1:0] slot_q, slot_d;
   logic [AW-1:0]        arm_q, arm_d;
   logic [PW-1:0]        pls_q, pls_d;
   logic [DW-1:0]        cool_q, cool_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [SLOT_BITS-1:0] stop_q, stop_d;
   logic                 btop_q, btop_d;
   logic                 err_q, err_d;
   logic                 busy_q;
   logic [SW-1:0]        str_q, str_d;
   logic                 ures_q;

   logic                 sel_vld;
   logic [CW-1:0]        sel_c;
   logic [NUM_REQ-1:0]   sel_oh;
   logic [SLOT_BITS-1:0] sel_slot;

   // Lowest-index active channel wins.
   always_comb begin
      sel_vld  = 1'b0;
      sel_c    = '0;
      sel_oh   = '0;
      sel_slot = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (BOOT[i]) begin
            sel_vld     = 1'b1;
            sel_c       = CW'(i);
            sel_oh      = '0;
            sel_oh[i]   = 1'b1;
            sel_slot    = SLOT[i*SLOT_BITS +: SLOT_BITS];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      chan_d  = chan_q;
      slot_d  = slot_q;
      arm_d   = arm_q;
      pls_d   = pls_q;
      cool_d  = cool_q;
      grant_d = grant_q;
      stop_d  = stop_q;
      btop_d  = btop_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // A cycle carrying ERR is skipped so a held bad request pulses.
            if (CONFIGURED_top && sel_vld && !err_q) begin
               slot_d = sel_slot;
               if (sel_slot > MAXS) begin
                  err_d = 1'b1;
               end else begin
                  chan_d  = sel_c;
                  grant_d = sel_oh;
                  arm_d   = AW'(1);
                  if (ARM_CYCLES == 1) begin
                     state_d = S_FIRE;
                     btop_d  = 1'b1;
                     stop_d  = sel_slot;
                     pls_d   = PW'(1);
                  end else begin
                     state_d = S_ARM;
                  end
               end
            end
         end
         S_ARM: begin
            if (BOOT[chan_q] && CONFIGURED_top) begin
               arm_d = arm_q + 1'b1;
               if (arm_q == AW'(ARM_CYCLES - 1)) begin
                  state_d = S_FIRE;
                  btop_d  = 1'b1;
                  stop_d  = slot_q;
                  pls_d   = PW'(1);
               end
            end else begin
               state_d = S_IDLE;
               grant_d = '0;
            end
         end
         S_FIRE: begin
            if (pls_q == PW'(BOOT_PULSE)) begin
               state_d = S_COOL;
               btop_d  = 1'b0;
               cool_d  = DW'(1);
            end else begin
               pls_d = pls_q + 1'b1;
            end
         end
         S_COOL: begin
            if (cool_q == DW'(COOLDOWN)) begin
               state_d = S_IDLE;
               grant_d = '0;
            end else begin
               cool_d = cool_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      str_d = str_q;
      if (RESET_top) begin
         str_d = SW'(RESET_STRETCH);
      end else if (str_q != '0) begin
         str_d = str_q - 1'b1;
      end
   end

   always_ff @(posedge UserCLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         chan_q  <= '0;
         slot_q  <= '0;
         arm_q   <= '0;
         pls_q   <= '0;
         cool_q  <= '0;
         grant_q <= '0;
         stop_q  <= '0;
         btop_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         str_q   <= SW'(RESET_STRETCH);
         ures_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         chan_q  <= chan_d;
         slot_q  <= slot_d;
         arm_q   <= arm_d;
         pls_q   <= pls_d;
         cool_q  <= cool_d;
         grant_q <= grant_d;
         stop_q  <= stop_d;
         btop_q  <= btop_d;
         err_q   <= err_d;
         busy_q  <= (state_d != S_IDLE);
         str_q   <= str_d;
         ures_q  <= RESET_top | (str_d != '0) | ~CONFIGURED_top;
      end
   end

   assign GRANT    = grant_q;
   assign BUSY     = busy_q;
   assign ERR      = err_q;
   assign RESET    = ures_q;
   assign SLOT_top = stop_q;
   assign BOOT_top = btop_q;

endmodule
